timingsgen_v2: RTL and testbench
================================

// Module: timingsgen_v2
// PURPOSE
//  Parametrised video timing generator: raster counters, hsync/vsync/DE and visible-area counters from a VideoMode.
//  Adds a valid/ready mode-load handshake and frame-aligned (tear-free) mode switching.
//  Adds a pixel clock-enable for pixel repetition.
//  Sits between mode selection and the pattern/measurement pipeline. All outputs are registered.
// PARAMETERS
//  CW          12   counter width; VideoMode fields zero-extended or truncated to CW
//  FRAME_CW    16   frame counter width (only used with TIMINGSGEN_FRAMECOUNT_EN)
// PORTS
//  clock             in   1         pixel clock; single clock domain
//  reset             in   1         asynchronous, active-high reset
//  pix_en            in   1         pixel enable; when 0 all state and outputs hold
//  mode_in           in   VideoMode timing set: h/v total, sync, back_porch, active, sync_pol
//  mode_valid        in   1         mode_in offered
//  mode_ready        out  1         block can accept mode_in this cycle
//  mode_err          out  1         1-cycle pulse: offered mode rejected
//  counterX/Y        out  CW        raster position
//  visible_counterX/Y out CW        position relative to active origin (mod 2^CW)
//  hsync, vsync, de  out  1         sync/enable outputs, polarity from the active mode
//  frame_start       out  1         1-cycle pulse, registered alongside (counterX,counterY)==(0,0)
//  frame_count       out  FRAME_CW  frames started since the first mode was accepted
// BEHAVIOUR
//  Reset: state=IDLE; counters, visible counters, hsync, vsync, de, mode_err, frame_start, frame_count all 0; mode_ready=1.
//  Handshake: a mode is accepted when mode_valid & mode_ready; handshake is independent of pix_en.
//  Rejection: an offered mode with h_total<2 or v_total<2 is discarded, pulses mode_err, and leaves state unchanged.
//  States:
//   IDLE:    no raster; outputs stay at reset values. Accept -> active:=mode_in, counters 0,0, go RUN.
//   RUN:     mode_ready=1. Accept -> pending:=mode_in, go PEND.
//   PEND:    mode_ready=0; raster continues on the old mode.
//            At the frame end (pix_en & X==h_total-1 & Y==v_total-1): active:=pending, counters->0,0, go RUN.
//  Counters (pix_en=1):
//   X < h_total-1 -> X+1.
//   Otherwise X->0 and Y->(Y < v_total-1 ? Y+1 : 0).
//  Decoded outputs (pix_en=1), one cycle behind counters, each computed from the pre-update counter values:
//   hsync = (X<h_sync) ? h_sync_pol : ~h_sync_pol
//   vsync = (Y<v_sync) ? v_sync_pol : ~v_sync_pol
//   de    = 1 iff hs+hbp <= X < hs+hbp+h_active and vs+vbp <= Y < vs+vbp+v_active
//   visible_counterX = X+1-(h_sync+h_back_porch); visible_counterY = Y-(v_sync+v_back_porch)
//   All arithmetic is CW bits with wrap.
//  Decoded outputs use the mode that is active in the same cycle as the counter value, so no mixed-mode cycle appears.
//  Mode switch: the first cycle of the new mode decodes (0,0) of the new mode.
//  frame_start: asserted for exactly one pix_en cycle per frame.
//  Simultaneous events: if mode_valid arrives in PEND on the frame-end cycle, mode_ready=0 that cycle, so it is not accepted.
//   The mode is accepted next cycle in RUN and applies at the following frame end.
//  Reset mid-frame: immediate return to IDLE; the pending mode is lost.
// CONFIGURATION
//  TIMINGSGEN_FRAMECOUNT_EN
//   Defined: frame_count increments, wrapping modulo 2^FRAME_CW, on every frame_start.
//   Undefined: frame_count is tied to 0 and the counter logic is removed; frame_start is always present.
// TESTING
//  1. Reset, no mode offered 100 cycles -> all outputs 0, mode_ready=1.
//  2. Load 640x480 (800x525, hs96 hbp48, vs2 vbp33, neg pol) -> hsync low for X 0..95.
//     de first high with visible_counterX=1 when counter is (144,35); period 800x525 cycles.
//  3. In RUN at (100,10) load 1280x720 -> old timing to frame end.
//     The next cycle decodes (0,0) of 1650x750; mode_ready low until then.
//  4. Offer h_total=1 -> mode_err one cycle, state and raster unchanged, mode_ready stays 1.
//  5. pix_en toggled 1/0 each cycle -> raster period doubles; outputs identical to a pix_en=1 run sampled on enabled cycles.
//  6. FRAMECOUNT_EN, FRAME_CW=2, tiny mode 4x3 -> frame_count 0,1,2,3,0 at each frame_start.
//     Assert reset mid-frame -> all outputs 0 next cycle.

Source files
------------

// File: rtl/timingsgen_v2.sv
// Video timing generator: raster counters, sync/DE decode, frame-aligned mode switching.
// Optional frame counter enabled by defining TIMINGSGEN_FRAMECOUNT_EN.
package timingsgen_v2_pkg;
  localparam int MODE_W = 12;

  typedef struct packed {
    logic [MODE_W-1:0] h_total;
    logic [MODE_W-1:0] h_sync;
    logic [MODE_W-1:0] h_back_porch;
    logic [MODE_W-1:0] h_active;
    logic              h_sync_pol;
    logic [MODE_W-1:0] v_total;
    logic [MODE_W-1:0] v_sync;
    logic [MODE_W-1:0] v_back_porch;
    logic [MODE_W-1:0] v_active;
    logic              v_sync_pol;
  } video_mode_t;
endpackage

module timingsgen_v2
  import timingsgen_v2_pkg::*;
#(
  parameter int CW       = 12,
  parameter int FRAME_CW = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                pix_en,
  input  video_mode_t         mode_in,
  input  logic                mode_valid,
  output logic                mode_ready,
  output logic                mode_err,
  output logic [CW-1:0]       counterX,
  output logic [CW-1:0]       counterY,
  output logic [CW-1:0]       visible_counterX,
  output logic [CW-1:0]       visible_counterY,
  output logic                hsync,
  output logic                vsync,
  output logic                de,
  output logic                frame_start,
  output logic [FRAME_CW-1:0] frame_count,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  video_mode_t r_active, r_pending;
  logic [CW-1:0] r_x, r_y, r_vis_x, r_vis_y;
  logic r_hsync, r_vsync, r_de, r_frame_start, r_mode_err;

  // Handshake: mode_in transfers on mode_valid & mode_ready, regardless of pix_en.
  logic w_bad, w_load, w_frame_end, w_x_wrap, w_y_wrap;
  logic [CW-1:0] w_h_total, w_h_sync, w_h_bp, w_h_act;
  logic [CW-1:0] w_v_total, w_v_sync, w_v_bp, w_v_act;
  logic [CW-1:0] w_h_start, w_v_start, w_x_nxt, w_y_nxt;
  logic w_de_h, w_de_v;

  assign w_h_total = CW'(r_active.h_total);
  assign w_h_sync  = CW'(r_active.h_sync);
  assign w_h_bp    = CW'(r_active.h_back_porch);
  assign w_h_act   = CW'(r_active.h_active);
  assign w_v_total = CW'(r_active.v_total);
  assign w_v_sync  = CW'(r_active.v_sync);
  assign w_v_bp    = CW'(r_active.v_back_porch);
  assign w_v_act   = CW'(r_active.v_active);

  assign mode_ready = (r_state != S_PEND);
  assign w_bad  = (CW'(mode_in.h_total) < CW'(2)) || (CW'(mode_in.v_total) < CW'(2));
  assign w_load = mode_valid & mode_ready & ~w_bad;

  assign w_x_wrap = !(r_x < w_h_total - CW'(1));
  assign w_y_wrap = !(r_y < w_v_total - CW'(1));
  assign w_x_nxt  = w_x_wrap ? '0 : r_x + CW'(1);
  assign w_y_nxt  = w_x_wrap ? (w_y_wrap ? '0 : r_y + CW'(1)) : r_y;
  assign w_frame_end = pix_en && (r_state == S_PEND) &&
                       (r_x == w_h_total - CW'(1)) && (r_y == w_v_total - CW'(1));

  assign w_h_start = w_h_sync + w_h_bp;
  assign w_v_start = w_v_sync + w_v_bp;
  assign w_de_h = (r_x >= w_h_start) && (r_x < w_h_start + w_h_act);
  assign w_de_v = (r_y >= w_v_start) && (r_y < w_v_start + w_v_act);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_load) w_state_nxt = S_RUN;
      S_RUN:   if (w_load) w_state_nxt = S_PEND;
      S_PEND:  if (w_frame_end) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Decode uses r_active of the same cycle as (r_x,r_y); the swap lands with counters at 0,0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_active      <= '0;
      r_pending     <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_vis_x       <= '0;
      r_vis_y       <= '0;
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_de          <= 1'b0;
      r_frame_start <= 1'b0;
      r_mode_err    <= 1'b0;
    end else begin
      r_mode_err <= mode_valid & mode_ready & w_bad;
      if (r_state == S_IDLE) begin
        if (w_load) r_active <= mode_in;
        r_x <= '0;
        r_y <= '0;
      end else begin
        if (r_state == S_RUN && w_load) r_pending <= mode_in;
        if (pix_en) begin
          r_x           <= w_x_nxt;
          r_y           <= w_y_nxt;
          r_hsync       <= (r_x < w_h_sync) ? r_active.h_sync_pol : ~r_active.h_sync_pol;
          r_vsync       <= (r_y < w_v_sync) ? r_active.v_sync_pol : ~r_active.v_sync_pol;
          r_de          <= w_de_h & w_de_v;
          r_vis_x       <= r_x + CW'(1) - w_h_start;
          r_vis_y       <= r_y - w_v_start;
          r_frame_start <= (r_x == '0) && (r_y == '0);
          if (w_frame_end) r_active <= r_pending;
        end
      end
    end
  end

`ifdef TIMINGSGEN_FRAMECOUNT_EN
  logic [FRAME_CW-1:0] r_frame_count;
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                         r_frame_count <= '0;
    else if (pix_en && r_frame_start)  r_frame_count <= r_frame_count + FRAME_CW'(1);
  end
  assign frame_count = r_frame_count;
`else
  assign frame_count = '0;
`endif

  assign counterX         = r_x;
  assign counterY         = r_y;
  assign visible_counterX = r_vis_x;
  assign visible_counterY = r_vis_y;
  assign hsync            = r_hsync;
  assign vsync            = r_vsync;
  assign de               = r_de;
  assign frame_start      = r_frame_start;
  assign mode_err         = r_mode_err;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_timingsgen_v2.sv
// Bench for timingsgen_v2: directed sequence plus random pix_en/mode traffic against a
// pixel-index reference model (position = frame pixel index, X = p % h_total, Y = p / h_total).
module tb_timingsgen_v2;
  import timingsgen_v2_pkg::*;

  localparam int CW   = 12;
  localparam int FCW  = 2;
  localparam int MASK = (1 << CW) - 1;

  logic clock = 1'b0;
  logic reset;
  logic pix_en;
  logic mode_valid;
  video_mode_t mode_in;
  logic mode_ready, mode_err, hsync, vsync, de, frame_start;
  logic [CW-1:0] counterX, counterY, visible_counterX, visible_counterY;
  logic [FCW-1:0] frame_count;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  timingsgen_v2 #(.CW(CW), .FRAME_CW(FCW)) dut (
    .clock(clock), .reset(reset), .pix_en(pix_en), .mode_in(mode_in),
    .mode_valid(mode_valid), .mode_ready(mode_ready), .mode_err(mode_err),
    .counterX(counterX), .counterY(counterY),
    .visible_counterX(visible_counterX), .visible_counterY(visible_counterY),
    .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start),
    .frame_count(frame_count), .o_dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  // Reference model state
  bit m_have, m_pend;
  int p;
  video_mode_t m_cur, m_nxt;
  bit e_hs, e_vs, e_de, e_fs, e_err;
  int e_vx, e_vy, e_fc;

  function automatic video_mode_t mk(input int ht, input int hs, input int hbp, input int ha,
                                     input bit hp, input int vt, input int vs, input int vbp,
                                     input int va, input bit vp);
    video_mode_t m;
    m.h_total = MODE_W'(ht);  m.h_sync = MODE_W'(hs);  m.h_back_porch = MODE_W'(hbp);
    m.h_active = MODE_W'(ha); m.h_sync_pol = hp;
    m.v_total = MODE_W'(vt);  m.v_sync = MODE_W'(vs);  m.v_back_porch = MODE_W'(vbp);
    m.v_active = MODE_W'(va); m.v_sync_pol = vp;
    return m;
  endfunction

  task automatic model_reset();
    m_have = 0; m_pend = 0; p = 0; m_cur = '0; m_nxt = '0;
    e_hs = 0; e_vs = 0; e_de = 0; e_fs = 0; e_err = 0; e_vx = 0; e_vy = 0; e_fc = 0;
  endtask

  task automatic model_edge(input bit en, input bit valid, input video_mode_t md);
    bit acc, bad;
    int ht, vt, x, y, hst, vst;
    acc = valid && !m_pend;
    bad = (int'(md.h_total) < 2) || (int'(md.v_total) < 2);
    e_err = acc && bad;
    if (!m_have) begin
      if (acc && !bad) begin m_have = 1; m_cur = md; p = 0; end
    end else begin
      if (en) begin
        ht = int'(m_cur.h_total); vt = int'(m_cur.v_total);
        x = p % ht; y = p / ht;
        hst = int'(m_cur.h_sync) + int'(m_cur.h_back_porch);
        vst = int'(m_cur.v_sync) + int'(m_cur.v_back_porch);
`ifdef TIMINGSGEN_FRAMECOUNT_EN
        if (e_fs) e_fc = (e_fc + 1) % (1 << FCW);
`endif
        e_hs = (x < int'(m_cur.h_sync)) ? m_cur.h_sync_pol : !m_cur.h_sync_pol;
        e_vs = (y < int'(m_cur.v_sync)) ? m_cur.v_sync_pol : !m_cur.v_sync_pol;
        e_de = (x >= hst) && (x < hst + int'(m_cur.h_active)) &&
               (y >= vst) && (y < vst + int'(m_cur.v_active));
        e_vx = (x + 1 - hst) & MASK;
        e_vy = (y - vst) & MASK;
        e_fs = (p == 0);
        p++;
        if (p == ht * vt) begin
          p = 0;
          if (m_pend) begin m_cur = m_nxt; m_pend = 0; end
        end
      end
      if (acc && !bad) begin m_pend = 1; m_nxt = md; end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int ex, ey;
    ex = m_have ? p % int'(m_cur.h_total) : 0;
    ey = m_have ? p / int'(m_cur.h_total) : 0;
    chk("counterX", int'(counterX), ex);
    chk("counterY", int'(counterY), ey);
    chk("visible_counterX", int'(visible_counterX), e_vx);
    chk("visible_counterY", int'(visible_counterY), e_vy);
    chk("hsync", int'(hsync), int'(e_hs));
    chk("vsync", int'(vsync), int'(e_vs));
    chk("de", int'(de), int'(e_de));
    chk("frame_start", int'(frame_start), int'(e_fs));
    chk("frame_count", int'(frame_count), e_fc);
    chk("mode_ready", int'(mode_ready), int'(!m_pend));
    chk("mode_err", int'(mode_err), int'(e_err));
  endtask

  task automatic cycle(input bit en, input bit valid, input video_mode_t md);
    pix_en = en; mode_valid = valid; mode_in = md;
    @(posedge clock); #1;
    model_edge(en, valid, md);
    check_all();
  endtask

  task automatic do_reset();
    pix_en = 0; mode_valid = 0; mode_in = '0;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  video_mode_t m640, m720, m_a, m_b, m_c, bad_h, bad_v;
  video_mode_t tbl[5];

  initial begin
    m640  = mk(800, 96, 48, 640, 1'b0, 525, 2, 33, 480, 1'b0);
    m720  = mk(1650, 40, 220, 1280, 1'b1, 750, 5, 20, 720, 1'b1);
    m_a   = mk(10, 2, 1, 6, 1'b1, 6, 1, 1, 3, 1'b1);
    m_b   = mk(12, 3, 2, 5, 1'b0, 5, 1, 1, 2, 1'b0);
    m_c   = mk(4, 1, 1, 2, 1'b1, 3, 1, 0, 2, 1'b0);
    bad_h = mk(1, 0, 0, 1, 1'b0, 5, 1, 1, 2, 1'b0);
    bad_v = mk(8, 1, 1, 4, 1'b0, 1, 0, 0, 1, 1'b0);
    tbl[0] = m_a; tbl[1] = m_b; tbl[2] = m_c; tbl[3] = bad_h; tbl[4] = bad_v;

    // Reset, then idle with no mode offered
    do_reset();
    for (int i = 0; i < 100; i++) cycle(1'($urandom_range(0, 1)), 1'b0, '0);

    // 640x480 through the first active line start at (144,35)
    cycle(1'b1, 1'b1, m640);
    for (int i = 0; i < 800 * 36 + 200; i++) cycle(1'b1, 1'b0, '0);

    // Rejected mode while running; then queue 720p, which waits for the frame end
    cycle(1'b1, 1'b1, bad_h);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, m720);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, '0);

    // Small modes: switch mid-frame, keep offering across the frame-end cycle
    do_reset();
    cycle(1'b1, 1'b1, m_a);
    for (int i = 0; i < 25; i++) cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, m_b);
    for (int i = 0; i < 150; i++) cycle(1'b1, 1'b1, m_c);
    cycle(1'b1, 1'b1, bad_v);

    // Alternating pix_en
    for (int i = 0; i < 200; i++) cycle(1'(i % 2), 1'b0, '0);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
            tbl[$urandom_range(0, 4)]);

    // Tiny 4x3 mode: frame counter wrap, then reset mid-frame with a mode pending
    do_reset();
    cycle(1'b1, 1'b1, m_c);
    for (int i = 0; i < 65; i++) cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, m_a);
    cycle(1'b1, 1'b0, '0);
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
